inst_mem_arbiter: RTL

Arbitrates the block-read miss ports of the instruction cache onto a single system memory block-read port. It sits directly downstream of the instruction cache's `mem_req`/`mem_rsp` ports and upstream of the system memory interface. One downstream read is in flight at a time. Requesters are granted round-robin, and any requester asking for the same block address is served by the same read (coalescing).

---
 rtl/sys.sv | 32 +++
 rtl/inst_mem_arbiter_if.sv | 31 +++
 rtl/rr_pick.sv | 34 +++
 rtl/inst_mem_arbiter.sv | 116 +++++++++++
 4 files changed

// File: rtl/sys.sv
`default_nettype none
// sys: system memory block-read types shared by the cache-side arbiters.
// Revision 1.0
package sys;

  typedef logic [31:0] addr_t;

  localparam int unsigned mem_block_size = 64;

  typedef logic [mem_block_size*8-1:0] block_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } mem_read_block_req_t;

  typedef struct packed {
    logic   done;
    block_t data;
  } mem_read_block_rsp_t;

  localparam mem_read_block_req_t mem_read_block_req_rst = '0;
  localparam mem_read_block_rsp_t mem_read_block_rsp_rst = '0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/inst_mem_arbiter_if.sv
`default_nettype none
// inst_mem_arbiter_if: upstream miss ports plus the single downstream block-read port.
// Revision 1.0
interface inst_mem_arbiter_if
  import sys::*;
#(
  parameter int PORT_CNT = 2
);

  mem_read_block_req_t up_req [PORT_CNT];
  mem_read_block_rsp_t up_rsp [PORT_CNT];
  mem_read_block_req_t mem_req;
  mem_read_block_rsp_t mem_rsp;

  // master is the arbiter; slave is the cache/memory environment around it
  modport master (
    input  up_req,
    input  mem_rsp,
    output up_rsp,
    output mem_req
  );

  modport slave (
    output up_req,
    output mem_rsp,
    input  up_rsp,
    input  mem_req
  );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// rr_pick: combinational round-robin first-valid finder starting at start_i.
// Revision 1.0
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] pos;

  // Walk offsets from farthest to nearest so the nearest valid port wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, start_i} + (IW + 1)'(k);
      if (pos >= (IW + 1)'(N)) begin
        pos = pos - (IW + 1)'(N);
      end
      if (valid_i[pos[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = pos[IW-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/inst_mem_arbiter.sv
`default_nettype none
// inst_mem_arbiter: round-robin, address-coalescing arbiter for I-cache block reads.
// Revision 1.0
module inst_mem_arbiter
  import sys::*;
#(
  parameter int PORT_CNT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  inst_mem_arbiter_if.master bus
);

  localparam int    IDX_W      = (PORT_CNT > 1) ? $clog2(PORT_CNT) : 1;
  localparam addr_t BLOCK_MASK = ~addr_t'(mem_block_size - 1);

  arb_state_t          state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_idx_q, grant_idx_d;
  addr_t               grant_addr_q, grant_addr_d;
  block_t              rsp_buf_q, rsp_buf_d;
  logic [PORT_CNT-1:0] serve_q, serve_d;

  logic [PORT_CNT-1:0] req_valid;
  logic [PORT_CNT-1:0] req_match;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;

  always_comb begin
    for (int j = 0; j < PORT_CNT; j++) begin
      req_valid[j] = bus.up_req[j].valid;
      req_match[j] = bus.up_req[j].valid &&
                     ((bus.up_req[j].addr & BLOCK_MASK) == grant_addr_q);
    end
  end

  rr_pick #(
    .N  (PORT_CNT),
    .IW (IDX_W)
  ) u_rr_pick (
    .valid_i (req_valid),
    .start_i (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    grant_addr_d = grant_addr_q;
    rsp_buf_d    = rsp_buf_q;
    serve_d      = serve_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          grant_idx_d  = pick_idx;
          grant_addr_d = bus.up_req[pick_idx].addr & BLOCK_MASK;
          state_d      = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        // The granted port may have withdrawn; only still-matching ports get the data.
        if (bus.mem_rsp.done) begin
          rsp_buf_d = bus.mem_rsp.data;
          serve_d   = req_match;
          state_d   = ARB_RESP;
        end
      end
      ARB_RESP: begin
        rr_ptr_d = (grant_idx_q == IDX_W'(PORT_CNT - 1)) ? '0 : grant_idx_q + 1'b1;
        state_d  = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= '0;
      grant_idx_q  <= '0;
      grant_addr_q <= '0;
      rsp_buf_q    <= '0;
      serve_q      <= '0;
    end else if (en) begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_idx_q  <= grant_idx_d;
      grant_addr_q <= grant_addr_d;
      rsp_buf_q    <= rsp_buf_d;
      serve_q      <= serve_d;
    end
  end

  // Outputs decode registered state only, so reset clears them asynchronously.
  always_comb begin
    bus.mem_req = mem_read_block_req_rst;
    if (state_q == ARB_ISSUE) begin
      bus.mem_req.valid = 1'b1;
      bus.mem_req.addr  = grant_addr_q;
    end
    for (int j = 0; j < PORT_CNT; j++) begin
      bus.up_rsp[j] = mem_read_block_rsp_rst;
      if ((state_q == ARB_RESP) && serve_q[j]) begin
        bus.up_rsp[j].done = 1'b1;
        bus.up_rsp[j].data = rsp_buf_q;
      end
    end
  end

endmodule
`default_nettype wire
